// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the single register-file write port between two writeback sources,
// the execute stage (EX) and the load/memory stage (MEM). Each source pushes
// results into its own DEPTH-entry FIFO over a valid/ready handshake. A
// round-robin arbiter drains one FIFO head per cycle into a registered write
// stage that drives the register file directly. Hazard stalls tell the issue
// stage when a source or destination register still has a buffered write.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   ex_valid/ex_ready        EX handshake; ex_addr/ex_data carry the result
//   mem_valid/mem_ready      MEM handshake; mem_addr/mem_data carry the result
//   raddr1, raddr2, issue_rd issue-stage source and destination registers
//   stall1, stall2, stall_rd buffered-write hazard on the matching address
//   we, waddr, wdata         register-file write port (registered)
//   idle                     both FIFOs empty and no write in flight
// ----------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int DEPTH    = 2,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 64,
   parameter int ZERO_REG = 31
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [ADDR_W-1:0] ex_addr,
   input  logic [DATA_W-1:0] ex_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   input  logic [ADDR_W-1:0] issue_rd,
   output logic              stall1,
   output logic              stall2,
   output logic              stall_rd,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] wdata,
   output logic              idle
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

   // Source index 0 is EX, 1 is MEM; the enum names the arbiter's choice.
   typedef enum logic {SRC_EX = 1'b0, SRC_MEM = 1'b1} src_e;

   logic [ADDR_W-1:0] q_addr [2][DEPTH];
   logic [DATA_W-1:0] q_data [2][DEPTH];
   logic [PTR_W-1:0]  rd_ptr [2];
   logic [PTR_W-1:0]  wr_ptr [2];
   logic [CNT_W-1:0]  count  [2];

   logic              in_valid [2];
   logic [ADDR_W-1:0] in_addr  [2];
   logic [DATA_W-1:0] in_data  [2];
   logic              ready    [2];
   logic              push     [2];
   logic              pop      [2];
   logic              nonempty [2];

   src_e              last_grant;
   src_e              grant_src;
   logic              grant_valid;
   logic              contention;
   logic [ADDR_W-1:0] grant_addr;
   logic [DATA_W-1:0] grant_data;

   assign in_valid[0] = ex_valid;
   assign in_addr[0]  = ex_addr;
   assign in_data[0]  = ex_data;
   assign in_valid[1] = mem_valid;
   assign in_addr[1]  = mem_addr;
   assign in_data[1]  = mem_data;

   // Readiness depends only on the registered count, so valid never loops
   // combinationally back into ready.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         ready[s]    = count[s] < FULL_CNT;
         nonempty[s] = count[s] != '0;
         push[s]     = in_valid[s] && ready[s];
      end
   end

   assign ex_ready  = ready[0];
   assign mem_ready = ready[1];

   // Round robin: on a two-way tie the source not granted last time wins.
   // NOTE: every output of a combinational block gets a default first, so no
   // path through the if/else chain leaves a variable unassigned (no latch).
   always_comb begin
      grant_valid = 1'b0;
      grant_src   = SRC_EX;
      contention  = 1'b0;
      if (nonempty[0] && nonempty[1]) begin
         grant_valid = 1'b1;
         contention  = 1'b1;
         grant_src   = (last_grant == SRC_MEM) ? SRC_EX : SRC_MEM;
      end else if (nonempty[0]) begin
         grant_valid = 1'b1;
         grant_src   = SRC_EX;
      end else if (nonempty[1]) begin
         grant_valid = 1'b1;
         grant_src   = SRC_MEM;
      end
   end

   assign pop[0]     = grant_valid && (grant_src == SRC_EX);
   assign pop[1]     = grant_valid && (grant_src == SRC_MEM);
   assign grant_addr = q_addr[grant_src][rd_ptr[grant_src]];
   assign grant_data = q_data[grant_src][rd_ptr[grant_src]];

   // NOTE: FIFO storage is deliberately left out of reset; an entry is only
   // ever read once the count marks it live, so its power-up value is unseen.
   always_ff @(posedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (push[s]) begin
            q_addr[s][wr_ptr[s]] <= in_addr[s];
            q_data[s][wr_ptr[s]] <= in_data[s];
         end
      end
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < 2; s++) begin
            rd_ptr[s] <= '0;
            wr_ptr[s] <= '0;
            count[s]  <= '0;
         end
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (push[s]) wr_ptr[s] <= wr_ptr[s] + 1'b1;
            if (pop[s])  rd_ptr[s] <= rd_ptr[s] + 1'b1;
            // Push and pop together leave the occupancy unchanged.
            if (push[s] && !pop[s])      count[s] <= count[s] + 1'b1;
            else if (!push[s] && pop[s]) count[s] <= count[s] - 1'b1;
         end
      end
   end

   // Only a genuine tie moves the round-robin pointer; MEM after reset so
   // that EX wins the first tie.
   always_ff @(posedge clk) begin
      if (rst)             last_grant <= SRC_MEM;
      else if (contention) last_grant <= grant_src;
   end

   // Registered write stage. Writes to the zero register are popped but
   // dropped; with no grant the address/data simply hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         we    <= 1'b0;
         waddr <= '0;
         wdata <= '0;
      end else if (grant_valid) begin
         we    <= grant_addr != ZERO_ADDR;
         waddr <= grant_addr;
         wdata <= grant_data;
      end else begin
         we    <= 1'b0;
      end
   end

   // An entry is live when its distance from the read pointer is below the
   // occupancy; pointers wrap naturally because DEPTH is a power of two.
   function automatic logic entry_live(input logic [PTR_W-1:0] idx,
                                       input logic [PTR_W-1:0] rd,
                                       input logic [CNT_W-1:0] cnt);
      logic [PTR_W-1:0] offset;
      offset = idx - rd;
      return CNT_W'(offset) < cnt;
   endfunction

   // Hazards cover buffered entries only; the write stage itself is covered
   // by the register file's same-cycle write-to-read forwarding.
   always_comb begin
      stall1   = 1'b0;
      stall2   = 1'b0;
      stall_rd = 1'b0;
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (entry_live(PTR_W'(i), rd_ptr[s], count[s])) begin
               if (q_addr[s][i] == raddr1)   stall1   = 1'b1;
               if (q_addr[s][i] == raddr2)   stall2   = 1'b1;
               if (q_addr[s][i] == issue_rd) stall_rd = 1'b1;
            end
         end
      end
      if (raddr1 == ZERO_ADDR)   stall1   = 1'b0;
      if (raddr2 == ZERO_ADDR)   stall2   = 1'b0;
      if (issue_rd == ZERO_ADDR) stall_rd = 1'b0;
   end

   assign idle = (count[0] == '0) && (count[1] == '0) && !we;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed scenarios followed by randomized traffic. A queue-based reference
// model (one queue per source, a round-robin bit and the expected write port)
// predicts every output; outputs are sampled just after the falling edge.
// ----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

   localparam int DEPTH    = 2;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 64;
   localparam int ZERO_REG = 31;

   logic              clk = 1'b0;
   logic              rst;
   logic              ex_valid, mem_valid;
   logic              ex_ready, mem_ready;
   logic [ADDR_W-1:0] ex_addr, mem_addr;
   logic [DATA_W-1:0] ex_data, mem_data;
   logic [ADDR_W-1:0] raddr1, raddr2, issue_rd;
   logic              stall1, stall2, stall_rd;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic              idle;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_REG(ZERO_REG)
   ) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr), .ex_data(ex_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
      .raddr1(raddr1), .raddr2(raddr2), .issue_rd(issue_rd),
      .stall1(stall1), .stall2(stall2), .stall_rd(stall_rd),
      .we(we), .waddr(waddr), .wdata(wdata), .idle(idle)
   );

   // ---------------- reference model ----------------
   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t            q_ex[$];
   entry_t            q_mem[$];
   bit                mem_won_last;   // tie-break memory: true -> EX wins next tie
   logic              m_we;
   logic [ADDR_W-1:0] m_waddr;
   logic [DATA_W-1:0] m_wdata;
   bit                ex_acc, mem_acc;
   logic [ADDR_W-1:0] wlog[$];

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit hazard(input logic [ADDR_W-1:0] a);
      if (a == ADDR_W'(ZERO_REG)) return 1'b0;
      foreach (q_ex[i])  if (q_ex[i].addr == a)  return 1'b1;
      foreach (q_mem[i]) if (q_mem[i].addr == a) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      q_ex.delete();
      q_mem.delete();
      mem_won_last = 1'b1;
      m_we = 1'b0; m_waddr = '0; m_wdata = '0;
      ex_acc = 1'b0; mem_acc = 1'b0;
   endtask

   // Advance the model by one rising edge using the inputs currently driven.
   task automatic model_step();
      bit     ex_ok, mem_ok, gv;
      entry_t g;
      if (rst) begin
         model_reset();
         return;
      end
      ex_ok  = ex_valid  && (q_ex.size()  < DEPTH);
      mem_ok = mem_valid && (q_mem.size() < DEPTH);
      gv = 1'b1;
      if (q_ex.size() > 0 && q_mem.size() > 0) begin
         if (mem_won_last) begin g = q_ex.pop_front();  mem_won_last = 1'b0; end
         else              begin g = q_mem.pop_front(); mem_won_last = 1'b1; end
      end else if (q_ex.size() > 0)  g = q_ex.pop_front();
      else if (q_mem.size() > 0)     g = q_mem.pop_front();
      else gv = 1'b0;
      if (gv) begin
         m_we    = (g.addr != ADDR_W'(ZERO_REG));
         m_waddr = g.addr;
         m_wdata = g.data;
      end else begin
         m_we = 1'b0;
      end
      if (ex_ok)  q_ex.push_back('{ex_addr, ex_data});
      if (mem_ok) q_mem.push_back('{mem_addr, mem_data});
      ex_acc  = ex_ok;
      mem_acc = mem_ok;
   endtask

   // Check all outputs against the model, then take one clock edge.
   task automatic cycle();
      #1;
      check("ex_ready",  ex_ready,  q_ex.size()  < DEPTH);
      check("mem_ready", mem_ready, q_mem.size() < DEPTH);
      check("stall1",    stall1,    hazard(raddr1));
      check("stall2",    stall2,    hazard(raddr2));
      check("stall_rd",  stall_rd,  hazard(issue_rd));
      check("we",        we,        m_we);
      check("waddr",     waddr,     m_waddr);
      check("wdata",     wdata,     m_wdata);
      check("idle",      idle,      (q_ex.size() == 0) && (q_mem.size() == 0) && !m_we);
      if (we) wlog.push_back(waddr);
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   function automatic logic [ADDR_W-1:0] rand_addr();
      int r;
      r = $urandom_range(0, 9);
      return (r == 9) ? ADDR_W'(ZERO_REG) : ADDR_W'(r);
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      bit     saw_not_ready;
      int     ei, mi, n;
      logic [ADDR_W-1:0] exp_seq [8];
      exp_seq = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};

      rst = 1'b1;
      ex_valid = 1'b0; mem_valid = 1'b0;
      ex_addr = '0; mem_addr = '0; ex_data = '0; mem_data = '0;
      raddr1 = '0; raddr2 = '0; issue_rd = '0;
      @(posedge clk);
      model_reset();
      @(negedge clk);
      cycle();
      rst = 1'b0;
      check("rst_we", we, 1'b0);
      check("rst_waddr", waddr, '0);
      check("rst_wdata", wdata, '0);
      check("rst_idle", idle, 1'b1);
      check("rst_ready", {ex_ready, mem_ready}, 2'b11);

      // EX only: push at edge 1, write visible after edge 2, idle after edge 3.
      ex_valid = 1'b1; ex_addr = 5'd3; ex_data = 64'hAAAA;
      cycle();
      ex_valid = 1'b0;
      cycle();
      check("exonly_we", we, 1'b1);
      check("exonly_waddr", waddr, 5'd3);
      check("exonly_wdata", wdata, 64'hAAAA);
      cycle();
      check("exonly_idle", idle, 1'b1);

      // Contention: both sources hold each item until it is accepted.
      wlog.delete();
      ei = 0; mi = 0; saw_not_ready = 1'b0;
      for (int c = 0; c < 30 && !(ei == 4 && mi == 4 && idle); c++) begin
         ex_valid  = (ei < 4); ex_addr  = ADDR_W'(ei + 1);  ex_data  = 64'(100 + ei);
         mem_valid = (mi < 4); mem_addr = ADDR_W'(mi + 11); mem_data = 64'(200 + mi);
         if ((ex_valid && !ex_ready) || (mem_valid && !mem_ready)) saw_not_ready = 1'b1;
         cycle();
         if (ex_acc)  ei++;
         if (mem_acc) mi++;
      end
      ex_valid = 1'b0; mem_valid = 1'b0;
      check("cont_drained", idle, 1'b1);
      check("cont_backpressure", saw_not_ready, 1'b1);
      check("cont_len", wlog.size(), 8);
      for (int i = 0; i < 8; i++)
         check($sformatf("cont_order%0d", i), (i < wlog.size()) ? wlog[i] : 5'h0, exp_seq[i]);

      // Zero register: popped, never written, never stalls.
      raddr1 = 5'd31;
      ex_valid = 1'b1; ex_addr = 5'd31; ex_data = 64'h55;
      cycle();
      ex_valid = 1'b0;
      check("zero_stall1", stall1, 1'b0);
      cycle();
      check("zero_we", we, 1'b0);
      check("zero_idle", idle, 1'b1);
      cycle();

      // Hazard on a buffered MEM write, cleared at the pop edge.
      raddr1 = 5'd7; issue_rd = 5'd7;
      mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 64'h77;
      cycle();
      mem_valid = 1'b0;
      check("haz_stall1_hi", stall1, 1'b1);
      check("haz_stallrd_hi", stall_rd, 1'b1);
      cycle();
      check("haz_stall1_lo", stall1, 1'b0);
      check("haz_stallrd_lo", stall_rd, 1'b0);
      check("haz_we", we, 1'b1);
      check("haz_waddr", waddr, 5'd7);
      raddr1 = '0; issue_rd = '0;
      cycle();

      // Full boundary: EX fills while MEM takes the tie, then push+pop at count 1.
      ex_valid = 1'b1; ex_addr = 5'd20; ex_data = 64'h20;
      mem_valid = 1'b1; mem_addr = 5'd21; mem_data = 64'h21;
      cycle();
      ex_addr = 5'd22; ex_data = 64'h22; mem_valid = 1'b0;
      cycle();
      check("full_ex_ready", ex_ready, 1'b0);
      ex_addr = 5'd24; ex_data = 64'h24;
      cycle();
      check("full_waddr20", waddr, 5'd20);
      check("full_ready_back", ex_ready, 1'b1);
      cycle();
      ex_valid = 1'b0;
      check("full_waddr22", waddr, 5'd22);
      check("full_not_idle", idle, 1'b0);
      cycle();
      check("full_waddr24", waddr, 5'd24);
      check("full_wdata24", wdata, 64'h24);
      cycle();
      check("full_idle", idle, 1'b1);

      // Reset mid-operation discards everything buffered.
      for (int c = 0; c < 6; c++) begin
         if (!ex_valid || ex_acc)   begin ex_valid = 1'b1;  ex_addr = 5'(c + 1);  ex_data = 64'(c); end
         if (!mem_valid || mem_acc) begin mem_valid = 1'b1; mem_addr = 5'(c + 8); mem_data = 64'(c + 50); end
         cycle();
      end
      check("rstmid_busy", idle, 1'b0);
      check("rstmid_backpressure", !ex_ready || !mem_ready, 1'b1);
      rst = 1'b1; ex_valid = 1'b0; mem_valid = 1'b0;
      cycle();
      rst = 1'b0;
      check("rstmid_we", we, 1'b0);
      check("rstmid_ready", {ex_ready, mem_ready}, 2'b11);
      check("rstmid_idle", idle, 1'b1);
      n = 0;
      for (int c = 0; c < 4; c++) begin
         cycle();
         if (we) n++;
      end
      check("rstmid_no_write", n, 0);

      // Randomized traffic with held data under backpressure and rare resets.
      for (int c = 0; c < 600; c++) begin
         if (!ex_valid || ex_acc) begin
            ex_valid = ($urandom_range(0, 9) < 7);
            ex_addr  = rand_addr();
            ex_data  = {$urandom(), $urandom()};
         end
         if (!mem_valid || mem_acc) begin
            mem_valid = ($urandom_range(0, 9) < 6);
            mem_addr  = rand_addr();
            mem_data  = {$urandom(), $urandom()};
         end
         raddr1   = rand_addr();
         raddr2   = rand_addr();
         issue_rd = rand_addr();
         rst      = ($urandom_range(0, 99) == 0);
         cycle();
      end
      rst = 1'b0; ex_valid = 1'b0; mem_valid = 1'b0;
      for (int c = 0; c < 8; c++) cycle();
      check("final_idle", idle, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (we/waddr/wdata) between two writeback sources: the execute stage (EX) and the load/memory stage (MEM).
- Each source pushes results through a valid/ready handshake into its own small FIFO.
- A round-robin arbiter drains one FIFO head per cycle into a registered write stage that drives the 32 x 64-bit register file directly.
- Also produces hazard stalls for the issue stage, so no read or new destination targets a register whose write is still buffered.

Parameters:
- DEPTH, 2: entries per source FIFO (power of two, >=2).
- ADDR_W, 5: register address width.
- DATA_W, 64: register data width.
- ZERO_REG, 31: hard-wired zero register index; writes to it are discarded.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ex_valid  in  1  EX result valid
- ex_ready  out  1  EX FIFO can accept
- ex_addr  in  ADDR_W  EX destination register
- ex_data  in  DATA_W  EX result
- mem_valid  in  1  MEM result valid
- mem_ready  out  1  MEM FIFO can accept
- mem_addr  in  ADDR_W  MEM destination register
- mem_data  in  DATA_W  MEM result
- raddr1, raddr2, issue_rd  in  ADDR_W each  issue-stage source and destination registers
- stall1, stall2, stall_rd  out  1 each  buffered-write hazard on the matching address
- we  out  1  register-file write enable
- waddr  out  ADDR_W  register-file write address
- wdata  out  DATA_W  register-file write data
- idle  out  1  both FIFOs empty and we low

Behaviour:
- Reset (sync, rst=1 at posedge):
  - both FIFOs emptied and pointers zeroed; we=0, waddr=0, wdata=0.
  - Round-robin last-grant flag set to MEM, so EX wins the first tie.
  - Reset mid-operation discards all buffered writes.
- Readiness and push:
  - ex_ready/mem_ready = (count < DEPTH), a function of registered count only; no combinational path from valid.
  - Push on the posedge where valid && ready. A full FIFO ignores valid; the source must hold its data.
- Arbitration (combinational on FIFO heads, each cycle):
  - One head non-empty: grant it.
  - Both non-empty: grant the source not granted last; update the last-grant flag only on a two-way contention grant.
  - Granted head pops at the next posedge.
  - Simultaneous push and pop on the same FIFO leaves count unchanged. Pop occurs even when count==DEPTH, but ready was low that cycle, so no push.
- Write stage (registered):
  - At each posedge, we <= grant_valid && (grant_addr != ZERO_REG); waddr <= grant_addr; wdata <= grant_data.
  - With no grant, we <= 0 and waddr/wdata hold their previous values.
  - A ZERO_REG entry is popped but never produces we=1.
- Latency: push at edge k, pop and we=1 during cycle after edge k+1, register file commits at edge k+2.
- Throughput: 1 write/cycle total.
- Ordering:
  - Per-source order is strict FIFO.
  - Cross-source order for the same register is prevented by stall_rd; the issue stage must not issue while it is high.
- Hazards:
  - stallN = (raddrN != ZERO_REG) && raddrN matches the address of any valid entry in either FIFO; same for stall_rd with issue_rd.
  - The write stage is excluded from the match, because the register file forwards wdata for same-cycle raddr==waddr with we=1.
  - Purely combinational from registered FIFO state.
- idle = both counts 0 && !we.

Test Plan:
- EX only: push (addr 3, 0xAAAA) at edge 1 -> we=1, waddr=3, wdata=0xAAAA in cycle after edge 2; idle=1 after edge 3.
- Contention: both push every cycle for 4 cycles (EX addrs 1-4, MEM addrs 11-14) -> write sequence 1,11,2,12,3,13,4,14; ready drops when count=2 and the sources stall without data loss.
- Zero register: EX push addr 31 data 0x55 -> entry popped, we stays 0, stall1=0 for raddr1=31 throughout.
- Hazard: MEM FIFO holds addr 7, raddr1=7 and issue_rd=7 -> stall1=1 and stall_rd=1 until the pop edge, then 0 while we=1 with waddr=7.
- Full boundary: fill EX FIFO (DEPTH=2) while MEM is granted -> ex_ready=0. Push and pop in the same cycle at count=1 -> count stays 1.
- Reset mid-op: both FIFOs full, rst=1 for one edge -> we=0, counts 0, both ready=1, idle=1, no buffered write ever appears.
